// File: rtl/sort_e3.sv
// Running top-5 / bottom-5 merger: folds 5-entry sorted batches into global
// max and min lists and presents them through a valid/ready result handshake.
module sort_e3 #(
    parameter int Data_Width  = 8,
    parameter int Index_Width = 16
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              sorter_clr,
    input  logic [Index_Width+Data_Width-1:0] E2H_sorter_out0,
    input  logic [Index_Width+Data_Width-1:0] E2H_sorter_out1,
    input  logic [Index_Width+Data_Width-1:0] E2H_sorter_out2,
    input  logic [Index_Width+Data_Width-1:0] E2H_sorter_out3,
    input  logic [Index_Width+Data_Width-1:0] E2H_sorter_out4,
    input  logic [Index_Width+Data_Width-1:0] E2L_sorter_out0,
    input  logic [Index_Width+Data_Width-1:0] E2L_sorter_out1,
    input  logic [Index_Width+Data_Width-1:0] E2L_sorter_out2,
    input  logic [Index_Width+Data_Width-1:0] E2L_sorter_out3,
    input  logic [Index_Width+Data_Width-1:0] E2L_sorter_out4,
    input  logic                              E2_sort_en,
    input  logic                              E2_last_sort,
    output logic [Index_Width+Data_Width-1:0] E3_top_out0,
    output logic [Index_Width+Data_Width-1:0] E3_top_out1,
    output logic [Index_Width+Data_Width-1:0] E3_top_out2,
    output logic [Index_Width+Data_Width-1:0] E3_top_out3,
    output logic [Index_Width+Data_Width-1:0] E3_top_out4,
    output logic [Index_Width+Data_Width-1:0] E3_bot_out0,
    output logic [Index_Width+Data_Width-1:0] E3_bot_out1,
    output logic [Index_Width+Data_Width-1:0] E3_bot_out2,
    output logic [Index_Width+Data_Width-1:0] E3_bot_out3,
    output logic [Index_Width+Data_Width-1:0] E3_bot_out4,
    output logic [2:0]                        E3_result_cnt,
    output logic                              E3_result_valid,
    input  logic                              E3_result_ready,
    output logic                              E3_busy,
    output logic                              E3_drop_err
);

    localparam int W = Index_Width + Data_Width;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_list     [2][5];
    logic [4:0]   r_vld      [2];
    logic         r_drop_err;

    logic [W-1:0] w_in       [2][5];
    logic [W-1:0] w_cand     [2][10];
    logic [9:0]   w_cand_v   [2];
    logic [3:0]   w_rank     [2][10];
    logic [W-1:0] w_merged   [2][5];
    logic [4:0]   w_merged_v [2];
    logic         w_restart;
    logic         w_accept;
    logic         w_handshake;
    logic         w_drop;

    // Strict preference: valid beats invalid, then data, then lower index.
    function automatic logic beats(input logic a_v, input logic [W-1:0] a,
                                   input logic b_v, input logic [W-1:0] b,
                                   input logic is_max);
        logic [Data_Width-1:0]  ad, bd;
        logic [Index_Width-1:0] ai, bi;
        ad = a[Data_Width-1:0];
        bd = b[Data_Width-1:0];
        ai = a[W-1:Data_Width];
        bi = b[W-1:Data_Width];
        if (!a_v) return 1'b0;
        if (!b_v) return 1'b1;
        if (ad != bd) return is_max ? (ad > bd) : (ad < bd);
        return ai < bi;
    endfunction

    assign w_in[0][0] = E2H_sorter_out0;
    assign w_in[0][1] = E2H_sorter_out1;
    assign w_in[0][2] = E2H_sorter_out2;
    assign w_in[0][3] = E2H_sorter_out3;
    assign w_in[0][4] = E2H_sorter_out4;
    assign w_in[1][0] = E2L_sorter_out0;
    assign w_in[1][1] = E2L_sorter_out1;
    assign w_in[1][2] = E2L_sorter_out2;
    assign w_in[1][3] = E2L_sorter_out3;
    assign w_in[1][4] = E2L_sorter_out4;

    assign w_restart   = (r_state == DONE);
    assign w_handshake = (r_state == DONE) && E3_result_ready;
    assign w_accept    = E2_sort_en && ((r_state != DONE) || E3_result_ready);
    assign w_drop      = E2_sort_en && (r_state == DONE) && !E3_result_ready;

    // Rank each of the 10 candidates; earlier candidate positions (running
    // list first) win full ties, which makes the ranks a permutation.
    always_comb begin
        for (int unsigned l = 0; l < 2; l++) begin
            w_cand_v[l] = '0;
            for (int unsigned k = 0; k < 5; k++) begin
                w_cand[l][k]       = w_restart ? '0 : r_list[l][k];
                w_cand_v[l][k]     = !w_restart && r_vld[l][k];
                w_cand[l][k+5]     = w_in[l][k];
                w_cand_v[l][k+5]   = 1'b1;
            end
            for (int unsigned j = 0; j < 10; j++) begin
                w_rank[l][j] = '0;
                for (int unsigned i = 0; i < 10; i++) begin
                    if (i < j) begin
                        if (!beats(w_cand_v[l][j], w_cand[l][j], w_cand_v[l][i], w_cand[l][i], l == 0))
                            w_rank[l][j] = w_rank[l][j] + 4'd1;
                    end else if (i > j) begin
                        if (beats(w_cand_v[l][i], w_cand[l][i], w_cand_v[l][j], w_cand[l][j], l == 0))
                            w_rank[l][j] = w_rank[l][j] + 4'd1;
                    end
                end
            end
            w_merged_v[l] = '0;
            for (int unsigned k = 0; k < 5; k++) begin
                w_merged[l][k] = '0;
                for (int unsigned j = 0; j < 10; j++) begin
                    if (w_rank[l][j] == 4'(k)) begin
                        w_merged[l][k]   = w_cand[l][j];
                        w_merged_v[l][k] = w_cand_v[l][j];
                    end
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (E2_sort_en) w_next = E2_last_sort ? DONE : ACCUM;
            ACCUM:   if (E2_sort_en && E2_last_sort) w_next = DONE;
            DONE:    if (E3_result_ready) w_next = E2_sort_en ? (E2_last_sort ? DONE : ACCUM) : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || sorter_clr) r_state <= IDLE;
        else                       r_state <= w_next;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || sorter_clr) begin
            for (int unsigned l = 0; l < 2; l++) begin
                r_vld[l] <= '0;
                for (int unsigned k = 0; k < 5; k++) r_list[l][k] <= '0;
            end
            r_drop_err <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int unsigned l = 0; l < 2; l++) begin
                    r_vld[l] <= w_merged_v[l];
                    for (int unsigned k = 0; k < 5; k++) r_list[l][k] <= w_merged[l][k];
                end
            end else if (w_handshake) begin
                for (int unsigned l = 0; l < 2; l++) begin
                    r_vld[l] <= '0;
                    for (int unsigned k = 0; k < 5; k++) r_list[l][k] <= '0;
                end
            end
            if (w_drop) r_drop_err <= 1'b1;
        end
    end

    always_comb begin
        E3_result_cnt = '0;
        for (int unsigned k = 0; k < 5; k++)
            E3_result_cnt = E3_result_cnt + 3'(r_vld[0][k]);
    end

    assign E3_top_out0     = r_list[0][0];
    assign E3_top_out1     = r_list[0][1];
    assign E3_top_out2     = r_list[0][2];
    assign E3_top_out3     = r_list[0][3];
    assign E3_top_out4     = r_list[0][4];
    assign E3_bot_out0     = r_list[1][0];
    assign E3_bot_out1     = r_list[1][1];
    assign E3_bot_out2     = r_list[1][2];
    assign E3_bot_out3     = r_list[1][3];
    assign E3_bot_out4     = r_list[1][4];
    assign E3_result_valid = (r_state == DONE);
    assign E3_busy         = (r_state == DONE);
    assign E3_drop_err     = r_drop_err;

endmodule

// File: tb/tb_sort_e3.sv
// Scoreboard bench for sort_e3: a reference model collects every accepted
// entry of a set and selects the expected top/bottom 5 when the set closes.
module tb_sort_e3;

    localparam int DW = 8;
    localparam int IW = 16;
    localparam int W  = DW + IW;

    typedef struct packed {
        logic [5*W-1:0] top;
        logic [5*W-1:0] bot;
    } exp_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst, sorter_clr, E2_sort_en, E2_last_sort, E3_result_ready;
    logic [W-1:0] h [5];
    logic [W-1:0] l [5];
    logic [W-1:0] top [5];
    logic [W-1:0] bot [5];
    logic [2:0]   cnt;
    logic         valid, busy, drop;

    logic [W-1:0] hq [$];
    logic [W-1:0] lq [$];
    exp_t         sb [$];
    int           n_pass   = 0;
    int           n_checks = 0;

    always #5 sys_clk = ~sys_clk;

    sort_e3 #(.Data_Width(DW), .Index_Width(IW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sorter_clr(sorter_clr),
        .E2H_sorter_out0(h[0]), .E2H_sorter_out1(h[1]), .E2H_sorter_out2(h[2]),
        .E2H_sorter_out3(h[3]), .E2H_sorter_out4(h[4]),
        .E2L_sorter_out0(l[0]), .E2L_sorter_out1(l[1]), .E2L_sorter_out2(l[2]),
        .E2L_sorter_out3(l[3]), .E2L_sorter_out4(l[4]),
        .E2_sort_en(E2_sort_en), .E2_last_sort(E2_last_sort),
        .E3_top_out0(top[0]), .E3_top_out1(top[1]), .E3_top_out2(top[2]),
        .E3_top_out3(top[3]), .E3_top_out4(top[4]),
        .E3_bot_out0(bot[0]), .E3_bot_out1(bot[1]), .E3_bot_out2(bot[2]),
        .E3_bot_out3(bot[3]), .E3_bot_out4(bot[4]),
        .E3_result_cnt(cnt), .E3_result_valid(valid), .E3_result_ready(E3_result_ready),
        .E3_busy(busy), .E3_drop_err(drop)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b, input bit is_max);
        if (a[DW-1:0] != b[DW-1:0]) return is_max ? (a[DW-1:0] > b[DW-1:0]) : (a[DW-1:0] < b[DW-1:0]);
        return a[W-1:DW] < b[W-1:DW];
    endfunction

    // Selection over arrival order: a strictly-better test keeps the earliest
    // arrival on full ties.
    function automatic logic [5*W-1:0] best5(input bit is_max);
        logic [W-1:0]   q [$];
        bit             used [64];
        logic [5*W-1:0] r;
        int             bi;
        r = '0;
        if (is_max) q = hq; else q = lq;
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bi = -1;
            for (int i = 0; i < q.size(); i++)
                if (!used[i] && (bi < 0 || better(q[i], q[bi], is_max))) bi = i;
            if (bi >= 0) begin
                used[bi] = 1'b1;
                r[k*W +: W] = q[bi];
            end
        end
        return r;
    endfunction

    task automatic set_h(input int d0, input int d1, input int d2, input int d3, input int d4, input int ib);
        int d [5];
        d = '{d0, d1, d2, d3, d4};
        for (int k = 0; k < 5; k++) h[k] = {IW'(ib + k), DW'(d[k])};
    endtask

    task automatic set_l(input int d0, input int d1, input int d2, input int d3, input int d4, input int ib);
        int d [5];
        d = '{d0, d1, d2, d3, d4};
        for (int k = 0; k < 5; k++) l[k] = {IW'(ib + k), DW'(d[k])};
    endtask

    task automatic rand_batch();
        logic [W-1:0] t;
        for (int k = 0; k < 5; k++) begin
            h[k] = {IW'($urandom_range(0, 7)), DW'($urandom_range(0, 15))};
            l[k] = {IW'($urandom_range(0, 7)), DW'($urandom_range(0, 15))};
        end
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 4; k++) begin
                if (better(h[k+1], h[k], 1'b1)) begin t = h[k]; h[k] = h[k+1]; h[k+1] = t; end
                if (better(l[k+1], l[k], 1'b0)) begin t = l[k]; l[k] = l[k+1]; l[k+1] = t; end
            end
    endtask

    // Drives one batch for one edge; 'accepted' says whether the model takes it.
    task automatic send(input bit last, input bit accepted);
        E2_sort_en   = 1'b1;
        E2_last_sort = last;
        if (accepted) begin
            for (int k = 0; k < 5; k++) begin
                hq.push_back(h[k]);
                lq.push_back(l[k]);
            end
            if (last) begin
                sb.push_back('{top: best5(1'b1), bot: best5(1'b0)});
                hq.delete();
                lq.delete();
            end
        end
        @(negedge sys_clk);
        E2_sort_en   = 1'b0;
        E2_last_sort = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_valid"}, valid, 1);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_cnt"}, cnt, 5);
            for (int k = 0; k < 5; k++) begin
                check($sformatf("%s_top%0d", tag, k), top[k], e.top[k*W +: W]);
                check($sformatf("%s_bot%0d", tag, k), bot[k], e.bot[k*W +: W]);
            end
        end
    endtask

    task automatic ack();
        E3_result_ready = 1'b1;
        @(negedge sys_clk);
        E3_result_ready = 1'b0;
        check("ack_valid", valid, 0);
        check("ack_cnt", cnt, 0);
        check("ack_top0", top[0], 0);
    endtask

    initial begin
        int nb;
        sys_rst = 1'b1; sorter_clr = 1'b0; E2_sort_en = 1'b0; E2_last_sort = 1'b0;
        E3_result_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin h[k] = '0; l[k] = '0; end
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", cnt, 0);
        check("rst_drop", drop, 0);
        check("rst_top0", top[0], 0);
        check("rst_bot4", bot[4], 0);

        // single last batch
        set_h(90, 80, 70, 60, 50, 0);
        set_l(1, 2, 3, 4, 5, 5);
        send(1, 1);
        check("s1_top0_const", top[0], {16'd0, 8'd90});
        check("s1_bot4_const", bot[4], {16'd9, 8'd5});
        check_result("s1");
        ack();

        // two batches with data ties resolved by index
        set_h(50, 40, 30, 20, 10, 0);
        set_l(100, 110, 120, 130, 140, 0);
        send(0, 1);
        check("s2_accum_valid", valid, 0);
        check("s2_accum_busy", busy, 0);
        check("s2_accum_cnt", cnt, 5);
        set_h(45, 45, 5, 5, 5, 32);
        set_l(90, 95, 200, 210, 220, 32);
        send(1, 1);
        check("s2_top1_const", top[1], {16'd32, 8'd45});
        check("s2_top3_const", top[3], {16'd1, 8'd40});
        check("s2_bot0_const", bot[0], {16'd32, 8'd90});
        check_result("s2");
        ack();

        // full tie between running and incoming entry
        set_h(77, 9, 8, 7, 6, 3);
        set_l(7, 8, 9, 10, 11, 3);
        send(0, 1);
        set_h(77, 9, 2, 1, 0, 3);
        set_l(7, 8, 12, 13, 14, 3);
        send(1, 1);
        check("s3_top1_const", top[1], {16'd3, 8'd77});
        check_result("s3");
        ack();

        // drops while held, then simultaneous handshake with a new last batch
        set_h(60, 50, 40, 30, 20, 10);
        set_l(2, 3, 4, 5, 6, 10);
        send(1, 1);
        set_h(250, 240, 230, 220, 210, 40);
        set_l(0, 0, 0, 0, 0, 40);
        send(1, 0);
        check("s4_drop", drop, 1);
        send(0, 0);
        check_result("s4_held");
        set_h(33, 22, 11, 10, 9, 50);
        set_l(1, 1, 2, 2, 3, 50);
        E3_result_ready = 1'b1;
        send(1, 1);
        E3_result_ready = 1'b0;
        check_result("s4_new");
        check("s4_drop_sticky", drop, 1);
        ack();

        // clear mid-accumulation together with a batch
        set_h(99, 98, 97, 96, 95, 60);
        set_l(0, 1, 2, 3, 4, 60);
        send(0, 1);
        sorter_clr = 1'b1;
        set_h(200, 199, 198, 197, 196, 70);
        send(0, 0);
        sorter_clr = 1'b0;
        hq.delete();
        lq.delete();
        check("s5_valid", valid, 0);
        check("s5_busy", busy, 0);
        check("s5_cnt", cnt, 0);
        check("s5_drop", drop, 0);
        check("s5_top0", top[0], 0);
        set_h(12, 11, 10, 9, 8, 80);
        set_l(3, 4, 5, 6, 7, 80);
        send(1, 1);
        check("s5_top0_const", top[0], {16'd80, 8'd12});
        check_result("s5");
        ack();

        // random sets of 1..3 batches
        for (int s = 0; s < 8; s++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                rand_batch();
                send(b == nb - 1, 1);
            end
            check_result($sformatf("rnd%0d", s));
            ack();
        end

        // reset while in DONE
        rand_batch();
        send(1, 1);
        send(0, 0);
        check("s6_busy", busy, 1);
        check("s6_drop", drop, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        sb.delete();
        check("s6_valid", valid, 0);
        check("s6_busy0", busy, 0);
        check("s6_cnt", cnt, 0);
        check("s6_drop0", drop, 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s6_top%0d", k), top[k], 0);
            check($sformatf("s6_bot%0d", k), bot[k], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sort_e3.md
SORT_E3 -- requirements
Module: sort_e3

Interface
REQ-001 SHALL have parameter Data_Width, default 8, the width of the score field.
REQ-002 SHALL have parameter Index_Width, default 16, the width of the global index field.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port sorter_clr, input, 1 bit: synchronous clear of the running state.
REQ-006 SHALL have ports E2H_sorter_out0..4, input, Index_Width+Data_Width bits each: the batch's 5 largest entries, descending, packed {index, data}.
REQ-007 SHALL have ports E2L_sorter_out0..4, input, Index_Width+Data_Width bits each: the batch's 5 smallest entries, ascending, same packing.
REQ-008 SHALL have port E2_sort_en, input, 1 bit: batch valid, one cycle per batch.
REQ-009 SHALL have port E2_last_sort, input, 1 bit: the batch is the final one of a set; sampled only while E2_sort_en=1.
REQ-010 SHALL have ports E3_top_out0..4, output, Index_Width+Data_Width bits each: global top-5 of the set, descending.
REQ-011 SHALL have ports E3_bot_out0..4, output, Index_Width+Data_Width bits each: global bottom-5 of the set, ascending.
REQ-012 SHALL have port E3_result_cnt, output, 3 bits: number of valid slots in each output list (0..5).
REQ-013 SHALL have port E3_result_valid, output, 1 bit, and port E3_result_ready, input, 1 bit: the result handshake.
REQ-014 SHALL have port E3_busy, output, 1 bit: high while in state DONE.
REQ-015 SHALL have port E3_drop_err, output, 1 bit: sticky flag, set when a batch is dropped.

Function
REQ-016 SHALL keep two running lists of 5 entries (max list, min list), each with per-slot valid bits; invalid slots always lose comparisons.
REQ-017 SHALL treat data as unsigned; equal data SHALL rank the lower index first; a full tie SHALL rank the running entry before the incoming entry.
REQ-018 SHALL, on an accepted batch, merge the max list with the 5 H inputs and the min list with the 5 L inputs, keeping the best 5 of each 10, updated the next edge; all 5 inputs of an accepted batch count as valid.
REQ-019 SHALL implement states IDLE, ACCUM and DONE.
- IDLE: sort_en with last=0 -> ACCUM; sort_en with last=1 -> DONE.
- ACCUM: sort_en with last=1 -> DONE; otherwise stay in ACCUM.
- DONE: result_valid && result_ready -> IDLE.
REQ-020 SHALL assert E3_result_valid in DONE, holding E3_top_out*, E3_bot_out* and E3_result_cnt stable until the handshake completes.
REQ-021 SHALL have latency of one edge: a last batch accepted at edge N gives result_valid=1 and merged outputs after edge N.
REQ-022 SHALL, on the handshake, invalidate both running lists (all slots zero, valid bits zero).
REQ-023 SHALL, when E2_sort_en=1 in DONE with result_ready=1 (simultaneous handshake), complete the handshake and take that batch as the first of a new set (merged with empty lists); next state is ACCUM, or DONE if last=1.
REQ-024 SHALL, when E2_sort_en=1 in DONE with result_ready=0, drop the batch, set E3_drop_err, and leave the lists and state unchanged.
REQ-025 SHALL drive invalid output slots as all-zero; E3_result_cnt SHALL equal the valid count of the max list, which always equals that of the min list.
REQ-026 SHALL ignore E2_last_sort whenever E2_sort_en=0.
REQ-027 SHALL give sorter_clr priority over every event except reset: it invalidates both lists and clears state to IDLE, result_valid and drop_err; an E2_sort_en in the same cycle is discarded without setting drop_err.

Reset
REQ-028 SHALL, on sys_rst=1 at a clock edge, clear all output ports, list entries, valid bits and drop_err to 0 and set state to IDLE; sys_rst SHALL take priority over all other inputs.

Verification
REQ-029 SHALL pass this scenario: one batch with last=1, H data 90,80,70,60,50 at idx 0..4, L data 1,2,3,4,5 at idx 5..9 -> next cycle result_valid=1, cnt=5, top=90..50, bot=1..5.
REQ-030 SHALL pass this scenario: batch A top data 50,40,30,20,10 (idx 0..4), then batch B last=1 top data 45,45,5,5,5 (idx 32..36) -> top = 50/0, 45/32, 45/33, 40/1, 30/2.
REQ-031 SHALL pass this scenario: data tie 77 at running idx 3 vs incoming idx 3 -> the running entry is in the earlier slot.
REQ-032 SHALL pass this scenario: DONE held with ready=0 while sort_en pulses -> outputs unchanged and drop_err=1; then ready=1 together with sort_en last=1 -> handshake completes, result_valid=1 the next cycle with only the new batch's values.
REQ-033 SHALL pass this scenario: sorter_clr in mid-ACCUM, same cycle as sort_en -> state IDLE, lists invalid, drop_err=0; the next last batch yields only its own values.
REQ-034 SHALL pass this scenario: sys_rst=1 while in DONE -> after the next edge all outputs are 0, result_valid=0, busy=0 and cnt=0.
